// File: rtl/wishbone_clint_pkg.sv
// wishbone_clint_pkg: CLINT register offsets, reset constants and a byte-merge helper
package wishbone_clint_pkg;
    localparam logic [15:0] MSIP_ADDR      = 16'h0000;
    localparam logic [15:0] MTIMECMP_ADDR  = 16'h4000;
    localparam logic [15:0] MTIME_ADDR     = 16'hBFF8;
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                                input logic [63:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction
endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides the clock into a one-cycle tick every CLOCK_CYCLES_PER_TICK cycles
module clint_prescaler #(
    parameter int CLOCK_CYCLES_PER_TICK = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = CLOCK_CYCLES_PER_TICK > 1 ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick    = count_q == CW'(CLOCK_CYCLES_PER_TICK - 1);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/wishbone_clint.sv
// wishbone_clint: Wishbone classic responder holding the CLINT msip, mtimecmp and mtime registers
module wishbone_clint
    import wishbone_clint_pkg::*;
#(
    parameter int DATA_SIZE             = 32,
    parameter int CLOCK_CYCLES_PER_TICK = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   CYC_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    input  logic [15:0]            ADR_I,
    input  logic [DATA_SIZE/8-1:0] SEL_I,
    input  logic [DATA_SIZE-1:0]   DAT_I,
    output logic [DATA_SIZE-1:0]   DAT_O,
    output logic                   ACK_O,
    output logic [DATA_SIZE-1:0]   msip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);
    logic                 tick;
    logic                 ack_q, ack_d, msip_q, msip_d;
    logic [DATA_SIZE-1:0] dat_q, dat_d, bmask;
    logic [63:0]          mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [63:0]          wmask, wdat, rd64, mtime_inc;
    logic [15:0]          base;
    logic                 req, wr, word_hi, hit_msip, hit_cmp, hit_time;
    logic                 unused_adr;

    clint_prescaler #(.CLOCK_CYCLES_PER_TICK(CLOCK_CYCLES_PER_TICK)) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign unused_adr = ^ADR_I[1:0];

    always_comb begin
        req      = CYC_I & STB_I & ~ack_q;
        wr       = req & WE_I;
        base     = {ADR_I[15:3], 3'b000};
        // a 32-bit bus reaches the upper half of 64-bit registers through address bit 2
        word_hi  = DATA_SIZE == 32 && ADR_I[2];
        hit_msip = base == MSIP_ADDR && !word_hi;
        hit_cmp  = base == MTIMECMP_ADDR;
        hit_time = base == MTIME_ADDR;
        bmask    = '0;
        for (int i = 0; i < DATA_SIZE; i++) bmask[i] = SEL_I[i / 8];
        wmask      = 64'(bmask) << (word_hi ? 32 : 0);
        wdat       = 64'(DAT_I) << (word_hi ? 32 : 0);
        rd64       = hit_msip ? {63'b0, msip_q} : hit_cmp ? mtimecmp_q : hit_time ? mtime_q : '0;
        mtime_inc  = mtime_q + {63'b0, tick};
        ack_d      = req;
        dat_d      = req ? DATA_SIZE'(rd64 >> (word_hi ? 32 : 0)) : dat_q;
        msip_d     = wr && hit_msip && SEL_I[0] ? DAT_I[0] : msip_q;
        mtimecmp_d = wr && hit_cmp ? merge_bytes(mtimecmp_q, wdat, wmask) : mtimecmp_q;
        // written bytes override the tick, unwritten bytes keep the carried increment
        mtime_d    = wr && hit_time ? merge_bytes(mtime_inc, wdat, wmask) : mtime_inc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign ACK_O    = ack_q;
    assign DAT_O    = dat_q;
    assign msip     = DATA_SIZE'(msip_q);
    assign mtime    = mtime_q;
    assign mtimecmp = mtimecmp_q;
endmodule

// File: doc/wishbone_clint.md
Name: wishbone_clint

Overview:
- Wishbone classic responder that implements the core-local interruptor (CLINT) registers msip, mtimecmp and mtime.
- Sits on the system bus beside memory. Its register values drive the core's mem_msip, mem_mtime and mem_mtimecmp inputs directly.
- Owns the free-running mtime counter and its prescaler.
- The core compares mtime against mtimecmp; this block does not generate the interrupt itself.

Parameters:
- DATA_SIZE, 32, bus data width; legal values are 32 or 64. Byte-select width is DATA_SIZE/8.
- CLOCK_CYCLES_PER_TICK, 1, number of clock cycles per mtime increment; must be at least 1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (reset is asserted when reset=0).
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  16  byte address offset inside the CLINT window.
- SEL_I  in  DATA_SIZE/8  byte enables.
- DAT_I  in  DATA_SIZE  write data.
- DAT_O  out  DATA_SIZE  read data; valid while ACK_O=1.
- ACK_O  out  1  transfer acknowledge.
- msip  out  DATA_SIZE  software interrupt register; only bit 0 is implemented, all other bits are 0.
- mtime  out  64  timer counter.
- mtimecmp  out  64  timer compare value.

Behaviour:
- Register map, address aligned to DATA_SIZE/8 with the low bits ignored:
  - 0x0000 = msip.
  - 0x4000 = mtimecmp low word; 0x4004 = mtimecmp high word (DATA_SIZE=32 only).
  - 0xBFF8 = mtime low word; 0xBFFC = mtime high word (DATA_SIZE=32 only).
  - With DATA_SIZE=64, 0x4000 and 0xBFF8 each access the full 64-bit register.
- Reset values (while reset=0): ACK_O=0, DAT_O=0, msip=0, mtime=0, mtimecmp=all ones, prescaler count=0.
  - mtimecmp resets to all ones so no spurious timer interrupt occurs after reset.
- Handshake: Wishbone classic, single-cycle registered response.
  - ACK_O is set on the rising edge after a cycle where CYC_I & STB_I & ~ACK_O.
  - ACK_O is 0 in every other cycle. ACK_O is therefore never high for two consecutive cycles, and back-to-back requests are acknowledged every other cycle.
  - Latency from request to ACK_O is 1 clock.
- Read: DAT_O is registered on the same edge that sets ACK_O, using the address presented that cycle. DAT_O holds its value until the next acknowledged transfer.
  - msip reads as {0..., msip[0]}.
  - An mtime read returns the value before any same-edge increment.
- Write: committed on the same edge that sets ACK_O. Only the bytes with SEL_I set are updated; SEL_I=0 still produces ACK_O but changes nothing.
  - msip: only bit 0 is writable, taken from DAT_I[0] and only if SEL_I[0]=1.
- Unmapped address: ACK_O is still returned, reads give 0, writes are ignored. No error signal exists.
- Prescaler:
  - Counter counts 0 .. CLOCK_CYCLES_PER_TICK-1.
  - It wraps to 0 and produces a one-cycle tick on the cycle it reaches CLOCK_CYCLES_PER_TICK-1.
  - With CLOCK_CYCLES_PER_TICK=1, a tick occurs every cycle.
- mtime: increments by 1 on each tick and wraps from 2^64-1 to 0.
- Simultaneous bus write to mtime and a tick: the write wins for the written bytes.
  - Unwritten bytes take their incremented value, computed from the full 64-bit increment including carries.
  - The prescaler is not reset by a write.
- Reset asserted mid-transfer: all state returns to reset values immediately. A pending ACK_O is dropped; the initiator must restart the transfer.
- mtime, mtimecmp and msip outputs are direct register outputs, with no combinational path from the bus inputs.

Decomposition:
- Shared package/header entries:
  - Offset constants MSIP_ADDR=16'h0000, MTIMECMP_ADDR=16'h4000, MTIME_ADDR=16'hBFF8.
  - MTIMECMP_RESET=64'hFFFF_FFFF_FFFF_FFFF.
- One sub-module, clint_prescaler: parameter CLOCK_CYCLES_PER_TICK; ports clock, reset, tick.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, release, idle 5 cycles with CLOCK_CYCLES_PER_TICK=1 -> ACK_O=0, msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtime=5.
2. msip write/read: write 32'hFFFF_FFFF to 0x0000 with SEL_I=4'hF -> ACK_O high exactly 1 cycle after STB_I, msip=1. A following read returns DAT_O=32'h1.
3. Byte-enable on mtimecmp (DATA_SIZE=32): write 32'h1234_5678 to 0x4000 with SEL_I=4'b0011 -> mtimecmp=64'hFFFF_FFFF_FFFF_5678.
4. Write/tick collision: write mtime low word 0x0000_0010 on a tick edge -> mtime low word=0x10 after the edge. Separately, write low word 0xFFFF_FFFF with SEL_I=4'hF -> on the next tick, high word increments by 1 and low word=0.
5. Prescaler: CLOCK_CYCLES_PER_TICK=4, 20 cycles after reset release -> mtime=5. Back-to-back STB_I for 4 cycles -> ACK_O pattern 0,1,0,1.
6. Reset mid-transfer and unmapped access:
   - Assert reset in the cycle STB_I rises -> ACK_O stays 0.
   - After release, read 0x1000 -> ACK_O=1, DAT_O=0.
   - Write 0x1000 -> no register changes.
